mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 4: memory access cycles per transaction, legal range 1..15.
REQ-002 Parameter MAX_D_STREAK, default 3: maximum consecutive data grants while a fetch waits, legal range 1..7.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_b, input, 1: reset, asynchronous, active-low.
REQ-005 Port if_req / if_addr, input, 1 / 32: instruction-fetch read request and its address.
REQ-006 Port if_rdata / if_done, output, 32 / 1: fetched word; one-cycle completion pulse.
REQ-007 Port d_req / d_we / d_addr, input, 1 / 1 / 32: data request, write flag (1 = write), address.
REQ-008 Port d_wdata, input, 4x8 byte array: store data.
REQ-009 Port d_rdata / d_done, output, 4x8 byte array / 1: load data; one-cycle completion pulse.
REQ-010 Port mem_addr / mem_data_in / mem_write_en, output, 32 / 4x8 / 1: shared memory port.
REQ-011 Port mem_data_out, input, 4x8: memory read data.
REQ-012 Port busy, output, 1: high whenever the FSM is not in ARB_IDLE.

Function
REQ-013 The FSM SHALL have three states: ARB_IDLE, ARB_ACCESS, ARB_RESP.
REQ-014 ARB_IDLE with any request sampled high SHALL grant, latch owner, address, we and wdata, and go to ARB_ACCESS. Otherwise it stays in ARB_IDLE.
REQ-015 ARB_ACCESS SHALL last exactly MEM_LATENCY cycles, counted by a latency counter, then go to ARB_RESP.
REQ-016 ARB_RESP SHALL last one cycle, assert the owner's done, ignore all requests, then go to ARB_IDLE.
REQ-017 Latency timing: request seen in IDLE in cycle 0, ACCESS in cycles 1..MEM_LATENCY, done in cycle MEM_LATENCY+1, IDLE in cycle MEM_LATENCY+2.
REQ-018 The earliest back-to-back grant SHALL occur in cycle MEM_LATENCY+2.
REQ-019 mem_addr and mem_data_in SHALL be registered and driven from the latched values during ACCESS; both hold their last value otherwise.
REQ-020 mem_write_en SHALL be high only in the last ACCESS cycle of a data write; it is never high for fetches.
REQ-021 Read data SHALL be captured from mem_data_out at the end of the last ACCESS cycle into if_rdata or d_rdata.
REQ-022 if_rdata and d_rdata SHALL hold their values until that requester's next read completes; writes leave d_rdata unchanged.
REQ-023 Requesters SHALL hold req, address and data stable until done, and deassert req by the edge ending the done cycle (req_next = req & ~done).
REQ-024 A req still high in the cycle after done SHALL be treated as a new request.
REQ-025 Arbitration when both requests are high in ARB_IDLE: data wins, unless d_streak == MAX_D_STREAK, in which case fetch wins.
REQ-026 d_streak (3 bits) SHALL increment, saturating, on a data grant while if_req is high.
REQ-027 d_streak SHALL clear on any fetch grant, and on a data grant while if_req is low.
REQ-028 The owner SHALL be fixed from grant until the end of ARB_RESP; request changes during ACCESS have no effect.
REQ-029 if_done and d_done SHALL never be high in the same cycle.

Reset
REQ-030 rst_b low SHALL, immediately and regardless of the clock, force ARB_IDLE, clear the latency counter and d_streak, and abandon any in-flight access.
REQ-031 Reset values: mem_addr 0, mem_data_in 0, mem_write_en 0, if_rdata 0, d_rdata 0, if_done 0, d_done 0, busy 0.
REQ-032 No done pulse SHALL be issued for an access abandoned by reset.
REQ-033 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_b high.

Structure
REQ-034 A shared package SHALL hold arb_state_t (ARB_IDLE, ARB_ACCESS, ARB_RESP), arb_owner_t (OWN_IF, OWN_D), and the defaults for MEM_LATENCY and MAX_D_STREAK.
REQ-035 No sub-module: the latency counter and streak counter are inline; the memory model belongs to the bench only.

Verification
REQ-036 Single fetch: if_req=1, if_addr=0x0000_0040, memory returns 0x2408_0005 -> if_done in cycle 5, if_rdata=0x2408_0005, mem_write_en never 1.
REQ-037 Data write: d_we=1, d_addr=0x100, d_wdata={DE,AD,BE,EF} -> mem_write_en=1 only in cycle 4, mem_data_in={DE,AD,BE,EF}, d_done in cycle 5.
REQ-038 Contention: if_req and d_req held high continuously with MAX_D_STREAK=3 -> grant order D,D,D,I,D,D,D,I; if_done never coincides with d_done.
REQ-039 Reset mid-access: rst_b low in cycle 2 of a data write -> mem_write_en never asserted, no d_done, all outputs 0, busy=0 immediately.
REQ-040 Back-to-back: d_req re-raised in the cycle after d_done -> second grant in cycle 6, second d_done in cycle 11; request toggles during ACCESS have no effect.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int DEF_MEM_LATENCY  = 4;
    localparam int DEF_MAX_D_STREAK = 3;

    localparam int LAT_W    = 4;
    localparam int STREAK_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between an instruction-fetch and a data requester.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic [31:0]      if_rdata,
    output logic             if_done,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [3:0][7:0]  d_wdata,
    output logic [3:0][7:0]  d_rdata,
    output logic             d_done,
    output logic [31:0]      mem_addr,
    output logic [3:0][7:0]  mem_data_in,
    output logic             mem_write_en,
    input  logic [3:0][7:0]  mem_data_out,
    output logic             busy
);

    localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(MAX_D_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_SAT = '1;

    arb_state_t            state_q, state_d;
    arb_owner_t            owner_q, grant_owner;
    logic                  we_q;
    logic [LAT_W-1:0]      lat_cnt_q;
    logic [STREAK_W-1:0]   d_streak_q;
    logic                  grant;
    logic                  last_access;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_owner = OWN_D;
        last_access = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (if_req || d_req) begin
                    grant   = 1'b1;
                    state_d = ARB_ACCESS;
                    // Data has priority until it has starved a waiting fetch MAX_D_STREAK times.
                    if (d_req && !(if_req && d_streak_q == STREAK_CAP)) grant_owner = OWN_D;
                    else                                                grant_owner = OWN_IF;
                end
            end
            ARB_ACCESS: begin
                if (lat_cnt_q == '0) begin
                    last_access = 1'b1;
                    state_d     = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            lat_cnt_q   <= '0;
            d_streak_q  <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
        end else begin
            if (grant) begin
                owner_q   <= grant_owner;
                lat_cnt_q <= LAT_LOAD;
                if (grant_owner == OWN_D) begin
                    we_q        <= d_we;
                    mem_addr    <= d_addr;
                    mem_data_in <= d_wdata;
                    if (if_req && d_streak_q != STREAK_SAT) d_streak_q <= d_streak_q + STREAK_W'(1);
                    else if (!if_req)                       d_streak_q <= '0;
                end else begin
                    we_q       <= 1'b0;
                    mem_addr   <= if_addr;
                    d_streak_q <= '0;
                end
            end else if (state_q == ARB_ACCESS && lat_cnt_q != '0) begin
                lat_cnt_q <= lat_cnt_q - LAT_W'(1);
            end

            if (last_access && !we_q) begin
                if (owner_q == OWN_IF) if_rdata <= mem_data_out;
                else                   d_rdata  <= mem_data_out;
            end
        end
    end

    assign busy         = (state_q != ARB_IDLE);
    assign if_done      = (state_q == ARB_RESP) && (owner_q == OWN_IF);
    assign d_done       = (state_q == ARB_RESP) && (owner_q == OWN_D);
    assign mem_write_en = last_access && we_q;

endmodule
